register_bank: RTL and testbench
================================

REGISTER_BANK -- requirements
Module: register_bank

Interface
REQ-001 SHALL have parameter NBits, default 16, data width per register (even, 4..32).
REQ-002 SHALL have parameter NRegs, default 4, register count (power of two, 2..8).
REQ-003 SHALL have parameter Saturate, default 0: 0 means increment/decrement wrap; 1 means they clamp at the bounds.
REQ-004 SHALL have port clk  input  1  rising-edge clock, the single clock.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port funsel  input  3  operation select, shared by all registers.
REQ-007 SHALL have port e  input  NRegs  per-register enable mask.
REQ-008 SHALL have port i  input  NBits  load data.
REQ-009 SHALL have port asel  input  clog2(NRegs)  read port A register index.
REQ-010 SHALL have port bsel  input  clog2(NRegs)  read port B register index.
REQ-011 SHALL have port outa  output  NBits  contents of register asel.
REQ-012 SHALL have port outb  output  NBits  contents of register bsel.
REQ-013 SHALL have port limit  output  NRegs  per-register registered boundary flag.

Function
REQ-014 SHALL update register k on a rising clk only when e[k]=1; when e[k]=0, register k SHALL hold its value.
REQ-015 SHALL decode funsel as follows: 000 clear; 001 load i; 010 decrement; 011 increment; 100 load low (low half = i low half, high half = 0); 101 load high (high half = i low half, low half kept); 110 shift left logical by 1; 111 shift right arithmetic by 1.
REQ-016 SHALL, when Saturate=0, wrap increment from all-ones to 0 and decrement from 0 to all-ones, modulo 2^NBits.
REQ-017 SHALL, when Saturate=1, hold the register at all-ones on increment and at 0 on decrement when already at that bound.
REQ-018 SHALL set limit[k]=1 for exactly the cycle after any edge where register k was enabled for inc at all-ones, or for dec at 0 (both modes); otherwise limit[k]=0 after that edge.
REQ-019 SHALL apply the same operation independently to every enabled register when several e bits are set.
REQ-020 SHALL drive outa/outb combinationally from the register contents; a read of a register being written on the same edge SHALL return the pre-edge value until after the edge (no bypass).
REQ-021 SHALL allow asel=bsel, with outa equal to outb.
REQ-022 SHALL give zero latency for reads and one-cycle latency for writes and limit.

Reset
REQ-023 SHALL, on a rising clk with rst_n=0, clear all registers and limit to 0, regardless of e and funsel.
REQ-024 SHALL give rst_n priority over any operation in the same cycle; an inc/dec in flight SHALL be discarded and produce no limit pulse.
REQ-025 SHALL keep outa/outb at 0 from the first reset edge until the first enabled write after reset.

Structure
REQ-026 SHALL define the funsel encodings as named constants in shared package regbank_pkg.
REQ-027 SHALL implement one storage element as sub-module register_cell (NBits, Saturate, data, limit), instantiated NRegs times.
REQ-028 SHALL contain read multiplexers only at the register_bank level.

Verification
REQ-029 Reset scenario: NBits=16, NRegs=4; after loading 0x1234 into all registers, rst_n=0 for 1 cycle -> outa=outb=0 and limit=0000.
REQ-030 Wrap scenario: Saturate=0; load 0xFFFF into r2, then inc r2 -> r2=0x0000, limit=0100 for one cycle, then 0000.
REQ-031 Saturate scenario: Saturate=1; r1=0, dec r1 twice -> r1 stays 0x0000 and limit[1]=1 after each edge.
REQ-032 Multi-enable scenario: e=1111 with r0..r3=1,2,3,4 and funsel=011 -> registers become 2,3,4,5; e=0000 leaves them unchanged.
REQ-033 Half/shift scenario: r0=0xABCD; load high with i=0x0012 -> 0x12CD; then shift right arithmetic -> 0x0966; then shift left -> 0x12CC.
REQ-034 Read-during-write scenario: asel=bsel=3; load 0x5A5A into r3 -> outa=outb show the old value before the edge and 0x5A5A after it.

Source files
------------

// File: rtl/regbank_pkg.sv
// regbank_pkg
//   Shared definitions for the register bank: the operation-select encoding
//   that every register cell decodes identically.
package regbank_pkg;

  typedef enum logic [2:0] {
    FS_CLEAR     = 3'b000,  // register <= 0
    FS_LOAD      = 3'b001,  // register <= i
    FS_DEC       = 3'b010,  // register <= register - 1 (wrap or clamp at 0)
    FS_INC       = 3'b011,  // register <= register + 1 (wrap or clamp at all-ones)
    FS_LOAD_LOW  = 3'b100,  // low half <= i low half, high half <= 0
    FS_LOAD_HIGH = 3'b101,  // high half <= i low half, low half kept
    FS_SHL       = 3'b110,  // logical shift left by 1
    FS_SRA       = 3'b111   // arithmetic shift right by 1
  } funsel_e;

endpackage

// File: rtl/register_cell.sv
// register_cell
//   One storage element of the register bank plus its registered boundary
//   flag. Executes the shared operation when enabled, otherwise holds.
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   synchronous active-low reset (clears data and limit)
//   en      in   write enable for this cell
//   funsel  in   operation select (regbank_pkg::funsel_e encoding)
//   din     in   load data
//   dout    out  current register contents
//   limit   out  1 for the cycle after an inc at all-ones or dec at 0
module register_cell
  import regbank_pkg::*;
#(
  parameter int NBits    = 16,
  parameter int Saturate = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       funsel,
  input  logic [NBits-1:0] din,
  output logic [NBits-1:0] dout,
  output logic             limit
);

  localparam int Half = NBits / 2;

  logic [NBits-1:0] r_data;
  logic             r_limit;
  logic [NBits-1:0] w_next;
  logic             w_hit;
  logic             w_at_max;
  logic             w_at_min;

  assign w_at_max = &r_data;
  assign w_at_min = ~|r_data;

  always_comb begin
    w_next = r_data;
    w_hit  = 1'b0;
    case (funsel_e'(funsel))
      FS_CLEAR:     w_next = '0;
      FS_LOAD:      w_next = din;
      FS_DEC: begin
        // The boundary flag fires in both modes; only the value differs.
        w_hit = w_at_min;
        if (Saturate != 0 && w_at_min) w_next = r_data;
        else                           w_next = r_data - {{(NBits-1){1'b0}}, 1'b1};
      end
      FS_INC: begin
        w_hit = w_at_max;
        if (Saturate != 0 && w_at_max) w_next = r_data;
        else                           w_next = r_data + {{(NBits-1){1'b0}}, 1'b1};
      end
      FS_LOAD_LOW:  w_next = {{Half{1'b0}}, din[Half-1:0]};
      FS_LOAD_HIGH: w_next = {din[Half-1:0], r_data[Half-1:0]};
      FS_SHL:       w_next = {r_data[NBits-2:0], 1'b0};
      FS_SRA:       w_next = {r_data[NBits-1], r_data[NBits-1:1]};
      default:      w_next = r_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_limit <= 1'b0;
    end else begin
      // limit is re-evaluated every edge, so it is a single-cycle pulse.
      r_limit <= en & w_hit;
      if (en) r_data <= w_next;
    end
  end

  assign dout  = r_data;
  assign limit = r_limit;

endmodule

// File: rtl/register_bank.sv
// register_bank
//   NRegs registers of NBits each sharing one operation select, with a
//   per-register enable mask and two combinational read ports.
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   synchronous active-low reset
//   funsel  in   operation select shared by all registers
//   e       in   per-register enable mask
//   i       in   load data
//   asel    in   read port A register index
//   bsel    in   read port B register index
//   outa    out  contents of register asel (pre-edge value, no bypass)
//   outb    out  contents of register bsel
//   limit   out  per-register registered boundary flag
module register_bank
  import regbank_pkg::*;
#(
  parameter int NBits    = 16,
  parameter int NRegs    = 4,
  parameter int Saturate = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [2:0]               funsel,
  input  logic [NRegs-1:0]         e,
  input  logic [NBits-1:0]         i,
  input  logic [$clog2(NRegs)-1:0] asel,
  input  logic [$clog2(NRegs)-1:0] bsel,
  output logic [NBits-1:0]         outa,
  output logic [NBits-1:0]         outb,
  output logic [NRegs-1:0]         limit
);

  logic [NBits-1:0] w_regs [NRegs];

  genvar gi;
  generate
    for (gi = 0; gi < NRegs; gi++) begin : g_cell
      register_cell #(
        .NBits    (NBits),
        .Saturate (Saturate)
      ) u_cell (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (e[gi]),
        .funsel (funsel),
        .din    (i),
        .dout   (w_regs[gi]),
        .limit  (limit[gi])
      );
    end
  endgenerate

  // Reads come straight off the stored values, so a same-edge write is only
  // visible after the edge.
  assign outa = w_regs[asel];
  assign outb = w_regs[bsel];

endmodule

// File: tb/tb_register_bank.sv
module tb_register_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  funsel;
  logic [3:0]  e;
  logic [15:0] i;
  logic [1:0]  asel;
  logic [1:0]  bsel;
  logic [15:0] outa_w, outb_w, outa_s, outb_s;
  logic [3:0]  limit_w, limit_s;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state for the wrapping and the saturating instance.
  int unsigned m_w [4];
  int unsigned m_s [4];
  logic [3:0]  ml_w;
  logic [3:0]  ml_s;

  always #5 clk = ~clk;

  register_bank #(.NBits(16), .NRegs(4), .Saturate(0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .funsel(funsel), .e(e), .i(i),
    .asel(asel), .bsel(bsel), .outa(outa_w), .outb(outb_w), .limit(limit_w)
  );

  register_bank #(.NBits(16), .NRegs(4), .Saturate(1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .funsel(funsel), .e(e), .i(i),
    .asel(asel), .bsel(bsel), .outa(outa_s), .outb(outb_s), .limit(limit_s)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Behavioural meaning of each operation on a 16-bit unsigned value.
  function automatic int unsigned model_op(input bit sat, input int unsigned v,
                                           input int unsigned fs, input int unsigned din,
                                           output bit hit);
    int unsigned r;
    hit = 1'b0;
    r   = v;
    case (fs)
      0: r = 0;
      1: r = din;
      2: if (v == 0) begin hit = 1'b1; r = sat ? 0 : 65535; end else r = v - 1;
      3: if (v == 65535) begin hit = 1'b1; r = sat ? 65535 : 0; end else r = v + 1;
      4: r = din % 256;
      5: r = (din % 256) * 256 + (v % 256);
      6: r = (v * 2) % 65536;
      7: r = v / 2 + ((v >= 32768) ? 32768 : 0);
      default: r = v;
    endcase
    return r;
  endfunction

  task automatic model_edge(input logic rst, input logic [2:0] fs,
                            input logic [3:0] en, input logic [15:0] din);
    bit hw, hs;
    for (int k = 0; k < 4; k++) begin
      if (!rst) begin
        m_w[k] = 0; m_s[k] = 0; ml_w[k] = 1'b0; ml_s[k] = 1'b0;
      end else begin
        ml_w[k] = 1'b0; ml_s[k] = 1'b0;
        if (en[k]) begin
          m_w[k] = model_op(1'b0, m_w[k], fs, din, hw);
          m_s[k] = model_op(1'b1, m_s[k], fs, din, hs);
          ml_w[k] = hw; ml_s[k] = hs;
        end
      end
    end
  endtask

  // Sweeps every register through both read ports of both instances.
  task automatic check_all(input string tag);
    for (int k = 0; k < 4; k++) begin
      asel = 2'(k);
      bsel = 2'(3 - k);
      #1;
      check_eq($sformatf("%s_wa%0d", tag, k), {16'h0, outa_w}, m_w[k]);
      check_eq($sformatf("%s_wb%0d", tag, 3 - k), {16'h0, outb_w}, m_w[3 - k]);
      check_eq($sformatf("%s_sa%0d", tag, k), {16'h0, outa_s}, m_s[k]);
      check_eq($sformatf("%s_sb%0d", tag, 3 - k), {16'h0, outb_s}, m_s[3 - k]);
    end
    check_eq({tag, "_limw"}, {28'h0, limit_w}, {28'h0, ml_w});
    check_eq({tag, "_lims"}, {28'h0, limit_s}, {28'h0, ml_s});
  endtask

  // Called between a negedge and the following posedge.
  task automatic step(input string tag, input logic rst, input logic [2:0] fs,
                      input logic [3:0] en, input logic [15:0] din);
    rst_n = rst; funsel = fs; e = en; i = din;
    @(posedge clk);
    model_edge(rst, fs, en, din);
    @(negedge clk);
    rst_n = 1'b1; e = 4'b0000;
    check_all(tag);
  endtask

  initial begin
    rst_n = 1'b0; funsel = 3'b000; e = 4'b0000; i = 16'h0; asel = 2'd0; bsel = 2'd0;
    for (int k = 0; k < 4; k++) begin m_w[k] = 0; m_s[k] = 0; end
    ml_w = 4'b0; ml_s = 4'b0;
    @(negedge clk);

    // Reset from power-up state
    step("rst0", 1'b0, 3'b000, 4'b0000, 16'h0);
    step("rst1", 1'b0, 3'b011, 4'b1111, 16'hFFFF);

    // Load 0x1234 everywhere, then one reset cycle
    step("ld1234", 1'b1, 3'b001, 4'b1111, 16'h1234);
    step("rstclr", 1'b0, 3'b001, 4'b1111, 16'h5555);
    asel = 2'd1; bsel = 2'd1; #1;
    check_eq("rst_outa", {16'h0, outa_w}, 32'h0);
    check_eq("rst_outb", {16'h0, outb_w}, 32'h0);

    // Reset discards an inc at all-ones: no limit pulse
    @(negedge clk);
    step("allff", 1'b1, 3'b001, 4'b1111, 16'hFFFF);
    step("rstinc", 1'b0, 3'b011, 4'b1111, 16'h0);
    check_eq("rstinc_lim", {28'h0, limit_w}, 32'h0);

    // Wrap: r2 = 0xFFFF then inc
    @(negedge clk);
    step("wr_ld", 1'b1, 3'b001, 4'b0100, 16'hFFFF);
    step("wr_inc", 1'b1, 3'b011, 4'b0100, 16'h0);
    asel = 2'd2; bsel = 2'd2; #1;
    check_eq("wrap_r2", {16'h0, outa_w}, 32'h0);
    check_eq("wrap_lim", {28'h0, limit_w}, 32'h4);
    check_eq("sat_r2", {16'h0, outa_s}, 32'hFFFF);
    @(negedge clk);
    step("wr_idle", 1'b1, 3'b011, 4'b0000, 16'h0);
    check_eq("wrap_lim_end", {28'h0, limit_w}, 32'h0);

    // Saturate at 0: clear r1, dec twice
    @(negedge clk);
    step("sat_clr", 1'b1, 3'b000, 4'b0010, 16'h0);
    for (int n = 0; n < 2; n++) begin
      step($sformatf("sat_dec%0d", n), 1'b1, 3'b010, 4'b0010, 16'h0);
      asel = 2'd1; #1;
      check_eq($sformatf("sat_r1_%0d", n), {16'h0, outa_s}, 32'h0);
      check_eq($sformatf("sat_lim_%0d", n), {28'h0, limit_s}, 32'h2);
      @(negedge clk);
    end

    // Multi-enable increment
    for (int k = 0; k < 4; k++) step("me_ld", 1'b1, 3'b001, 4'(1 << k), 16'(k + 1));
    step("me_inc", 1'b1, 3'b011, 4'b1111, 16'h0);
    step("me_hold", 1'b1, 3'b011, 4'b0000, 16'h0);
    for (int k = 0; k < 4; k++) begin
      asel = 2'(k); #1;
      check_eq($sformatf("me_r%0d", k), {16'h0, outa_w}, 32'(k + 2));
    end
    @(negedge clk);

    // Half loads and shifts on r0
    step("hs_ld", 1'b1, 3'b001, 4'b0001, 16'hABCD);
    step("hs_hi", 1'b1, 3'b101, 4'b0001, 16'h0012);
    asel = 2'd0; #1; check_eq("hs_hi_r0", {16'h0, outa_w}, 32'h12CD);
    @(negedge clk);
    step("hs_sra", 1'b1, 3'b111, 4'b0001, 16'h0);
    asel = 2'd0; #1; check_eq("hs_sra_r0", {16'h0, outa_w}, 32'h0966);
    @(negedge clk);
    step("hs_shl", 1'b1, 3'b110, 4'b0001, 16'h0);
    asel = 2'd0; #1; check_eq("hs_shl_r0", {16'h0, outa_w}, 32'h12CC);
    @(negedge clk);
    step("hs_lo", 1'b1, 3'b100, 4'b0001, 16'hBEEF);

    // Read during write on r3, both ports on the same index
    @(negedge clk);
    asel = 2'd3; bsel = 2'd3; rst_n = 1'b1; funsel = 3'b001; e = 4'b1000; i = 16'h5A5A;
    #1;
    check_eq("rdw_pre_a", {16'h0, outa_w}, m_w[3]);
    check_eq("rdw_pre_b", {16'h0, outb_w}, m_w[3]);
    @(posedge clk);
    model_edge(1'b1, 3'b001, 4'b1000, 16'h5A5A);
    #1;
    check_eq("rdw_post_a", {16'h0, outa_w}, 32'h5A5A);
    check_eq("rdw_post_b", {16'h0, outb_w}, 32'h5A5A);
    @(negedge clk);
    e = 4'b0000;
    check_all("rdw");

    // Randomized operations, biased toward boundary values
    for (int n = 0; n < 300; n++) begin
      logic        r_rst;
      logic [2:0]  r_fs;
      logic [3:0]  r_en;
      logic [15:0] r_din;
      r_rst = ($urandom_range(0, 24) == 0) ? 1'b0 : 1'b1;
      r_fs  = 3'($urandom_range(0, 7));
      r_en  = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0:       r_din = 16'hFFFF;
        1:       r_din = 16'h0000;
        default: r_din = 16'($urandom);
      endcase
      step($sformatf("rnd%0d", n), r_rst, r_fs, r_en, r_din);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
